// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the multi-cycle MUL/DIV sequencer.
// Optional signed support is enabled with ALU_SEQ_SIGNED_EN.
package alu_seq_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 5;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/alu_seq_addsub.sv
// Combinational (WIDTH+1)-bit adder/subtractor.
// Shared by the shift-add multiply and restoring divide steps.
module alu_seq_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0] x,
    input  logic [WIDTH:0] y,
    input  logic           sub,
    output logic [WIDTH:0] sum,
    output logic           cout
);
    logic [WIDTH+1:0] w_full;

    // carry-out on add, borrow-out on subtract
    always_comb begin
        if (sub)
            w_full = {1'b0, x} - {1'b0, y};
        else
            w_full = {1'b0, x} + {1'b0, y};
    end

    assign sum  = w_full[WIDTH:0];
    assign cout = w_full[WIDTH+1];
endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer running 16-step shift-add MUL and restoring DIV.
// Define ALU_SEQ_SIGNED_EN for signed operands (sgn port, FIX state).
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sel,
`ifdef ALU_SEQ_SIGNED_EN
    input  logic             sgn,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             dbz
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_mq;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH:0]   w_x;
    logic [WIDTH:0]   w_y;
    logic             w_sub;
    logic [WIDTH:0]   w_sum;
    logic             w_co;
    logic [WIDTH:0]   w_acc_n;
    logic [WIDTH-1:0] w_mq_n;
    logic [WIDTH-1:0] w_a_ld;
    logic [WIDTH-1:0] w_b_ld;
    logic             w_dz;

`ifdef ALU_SEQ_SIGNED_EN
    logic               r_nq;
    logic               r_nr;
    logic [2*WIDTH-1:0] w_prod;

    // signed mode loads operand magnitudes
    assign w_a_ld = (sgn && a[WIDTH-1]) ? -a : a;
    assign w_b_ld = (sgn && b[WIDTH-1]) ? -b : b;
    assign w_prod = {r_acc[WIDTH-1:0], r_mq};
`else
    assign w_a_ld = a;
    assign w_b_ld = b;
`endif

    assign w_dz = (r_op == OP_DIV) && (r_opnd == '0);

    // operand selection for the shared add/sub step
    always_comb begin
        w_sub = (r_op == OP_DIV);
        if (r_op == OP_DIV) begin
            w_x = {r_acc[WIDTH-1:0], r_mq[WIDTH-1]};
            w_y = {1'b0, r_opnd};
        end else begin
            w_x = r_acc;
            w_y = r_mq[0] ? {1'b0, r_opnd} : '0;
        end
    end

    alu_seq_addsub #(.WIDTH(WIDTH)) u_addsub (
        .x    (w_x),
        .y    (w_y),
        .sub  (w_sub),
        .sum  (w_sum),
        .cout (w_co)
    );

    // next {acc,mq}: shift right after add, or restore/commit after trial subtract
    always_comb begin
        if (r_op == OP_DIV) begin
            w_acc_n = w_co ? w_x : w_sum;
            w_mq_n  = {r_mq[WIDTH-2:0], ~w_co};
        end else begin
            w_acc_n = {1'b0, w_sum[WIDTH:1]};
            w_mq_n  = {w_sum[0], r_mq[WIDTH-1:1]};
        end
    end

    // control FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= 1'b0;
            r_opnd  <= '0;
            r_acc   <= '0;
            r_mq    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef ALU_SEQ_SIGNED_EN
            r_nq    <= 1'b0;
            r_nr    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_op    <= op_sel;
                        r_acc   <= '0;
                        r_opnd  <= op_sel ? w_b_ld : w_a_ld;
                        r_mq    <= op_sel ? w_a_ld : w_b_ld;
`ifdef ALU_SEQ_SIGNED_EN
                        r_nq    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_nr    <= sgn & a[WIDTH-1];
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_n;
                    r_mq  <= w_mq_n;
                    if (r_cnt == LAST) begin
`ifdef ALU_SEQ_SIGNED_EN
                        r_state <= FIX;
`else
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_dbz   <= w_dz;
                        r_hi    <= w_acc_n[WIDTH-1:0];
                        r_lo    <= w_mq_n;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef ALU_SEQ_SIGNED_EN
                FIX: begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_dbz   <= w_dz;
                    if (r_op == OP_DIV) begin
                        r_lo <= r_nq ? -r_mq : r_mq;
                        r_hi <= r_nr ? -r_acc[WIDTH-1:0]
                                     : r_acc[WIDTH-1:0];
                    end else begin
                        {r_hi, r_lo} <= r_nq ? -w_prod : w_prod;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign dbz    = r_dbz;
    assign res_hi = r_hi;
    assign res_lo = r_lo;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl (default unsigned build).
// Driver pushes expected results; monitor pops on every done pulse.
module tb_alu_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op_sel = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, dbz;
    logic [15:0] res_hi, res_lo;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   bcnt = 0;

    alu_seq_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_sel (op_sel),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .dbz    (dbz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    // reference: plain arithmetic on the unsigned operands
    function automatic exp_t model(input logic op, input logic [15:0] x,
                                   input logic [15:0] y);
        exp_t e;
        logic [31:0] p;
        e.cyc = 0;
        if (op == 1'b0) begin
            p    = {16'h0, x} * {16'h0, y};
            e.hi = p[31:16];
            e.lo = p[15:0];
            e.dz = 1'b0;
        end else if (y == 16'h0) begin
            e.hi = x;
            e.lo = 16'hFFFF;
            e.dz = 1'b1;
        end else begin
            e.hi = x % y;
            e.lo = x / y;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic issue(input logic op, input logic [15:0] x,
                         input logic [15:0] y);
        exp_t e;
        start  = 1'b1;
        op_sel = op;
        a      = x;
        b      = y;
        @(posedge clk);
        #1;
        e     = model(op, x, y);
        e.cyc = cyc;
        q.push_back(e);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            if (done) break;
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL done_timeout actual=none required=done");
        end
    endtask

    // monitor: compare every done pulse against the head of the queue
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            bcnt = 0;
        end else begin
            if (busy) bcnt++;
            if (done) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done actual=1 required=0");
                end else begin
                    e = q.pop_front();
                    chk("res_hi", {16'h0, res_hi}, {16'h0, e.hi});
                    chk("res_lo", {16'h0, res_lo}, {16'h0, e.lo});
                    chk("dbz", {31'h0, dbz}, {31'h0, e.dz});
                    chk("latency", cyc - e.cyc, 32'd16);
                    chk("busy_cycles", bcnt, 32'd16);
                    chk("busy_at_done", {31'h0, busy}, 32'd0);
                end
                bcnt = 0;
            end
        end
    end

    initial begin
        logic [15:0] x, y;
        logic        op;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'h0, busy}, 32'd0);
        chk("reset_done", {31'h0, done}, 32'd0);
        chk("reset_res", {res_hi, res_lo}, 32'd0);
        chk("reset_dbz", {31'h0, dbz}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(1'b0, 16'h00FF, 16'h0101);
        wait_done();
        issue(1'b0, 16'hFFFF, 16'hFFFF);
        wait_done();
        issue(1'b1, 16'd1000, 16'd7);
        wait_done();
        issue(1'b1, 16'd5, 16'd9);
        wait_done();
        repeat (2) @(posedge clk);
        #1;
        issue(1'b1, 16'h1234, 16'h0000);
        wait_done();
        issue(1'b0, 16'h0003, 16'h0004);
        wait_done();
        chk("hold_after_done", {res_hi, res_lo}, 32'd12);

        // start during RUN must be ignored
        issue(1'b0, 16'h1234, 16'h5678);
        repeat (4) @(posedge clk);
        #1;
        start  = 1'b1;
        op_sel = 1'b1;
        a      = 16'hAAAA;
        b      = 16'h0003;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        // async reset mid-run discards the op
        issue(1'b1, 16'hBEEF, 16'h0013);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_res", {res_hi, res_lo}, 32'd0);
        chk("rst_dbz", {31'h0, dbz}, 32'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        issue(1'b1, 16'd50000, 16'd123);
        wait_done();

        // randomized ops, sometimes back-to-back, sometimes idle gaps
        for (int i = 0; i < 40; i++) begin
            op = 1'($urandom_range(0, 1));
            x  = 16'($urandom);
            y  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) y = 16'h0;
            if ($urandom_range(0, 7) == 0) y = 16'hFFFF;
            issue(op, x, y);
            wait_done();
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) @(posedge clk);
            #0;
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
